bnn_accuracy_monitor: RTL



---
 rtl/bnn_accuracy_monitor.sv | 109 ++++++++++
 1 files changed

// File: rtl/bnn_accuracy_monitor.sv
// bnn_accuracy_monitor: pairs classifier results with queued ground-truth labels and keeps hit/total scores
// Ports: clk/rst (sync, active-high), i_clear soft clear;
//   i_in_valid/i_label push a label, i_res_valid/i_result pop and compare;
//   i_class_sel selects the per-class readout (o_class_correct/o_class_total);
//   o_match_valid/o_match compare strobe, o_correct/o_total global scores,
//   o_level queue occupancy, o_done/o_overflow/o_underflow sticky flags.
module bnn_accuracy_monitor #(
  parameter int N_CLASSES  = 10,
  parameter int LABEL_W    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16,
  parameter int N_SAMPLES  = 10000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_in_valid,
  input  logic [LABEL_W-1:0]            i_label,
  input  logic                          i_res_valid,
  input  logic [LABEL_W-1:0]            i_result,
  input  logic [LABEL_W-1:0]            i_class_sel,
  output logic                          o_match_valid,
  output logic                          o_match,
  output logic [CNT_W-1:0]              o_correct,
  output logic [CNT_W-1:0]              o_total,
  output logic [CNT_W-1:0]              o_class_correct,
  output logic [CNT_W-1:0]              o_class_total,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_done,
  output logic                          o_overflow,
  output logic                          o_underflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  logic [LABEL_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cls_cor [N_CLASSES];
  logic [CNT_W-1:0] cls_tot [N_CLASSES];
  logic active, full, empty, push, pop, hit;
  logic [LABEL_W-1:0] head;
  logic [CNT_W-1:0] tot_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + CNT_W'(1);
  endfunction

  // once done, the monitor freezes and ignores both streams
  always_comb begin
    active = !o_done;
    full   = o_level == LW'(FIFO_DEPTH);
    empty  = o_level == '0;
    pop    = active && i_res_valid && !empty;
    push   = active && i_in_valid && (!full || pop);
    head   = mem[rd_ptr];
    hit    = i_result == head;
    tot_nx = sat_inc(o_total);
  end

  // out-of-range selects fall through to zero
  always_comb begin
    o_class_correct = '0;
    o_class_total   = '0;
    for (int k = 0; k < N_CLASSES; k++) begin
      o_class_correct = (i_class_sel == LABEL_W'(k)) ? cls_cor[k] : o_class_correct;
      o_class_total   = (i_class_sel == LABEL_W'(k)) ? cls_tot[k] : o_class_total;
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= i_label;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_level       <= '0;
      o_match_valid <= 1'b0;
      o_match       <= 1'b0;
      o_correct     <= '0;
      o_total       <= '0;
      o_done        <= 1'b0;
      o_overflow    <= 1'b0;
      o_underflow   <= 1'b0;
      for (int k = 0; k < N_CLASSES; k++) begin
        cls_cor[k] <= '0;
        cls_tot[k] <= '0;
      end
    end else begin
      o_match_valid <= pop;
      o_match       <= pop && hit;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      o_level <= o_level + LW'(push) - LW'(pop);
      if (active && i_in_valid && full && !pop) o_overflow <= 1'b1;
      if (active && i_res_valid && empty) o_underflow <= 1'b1;
      if (pop) begin
        o_total <= tot_nx;
        if (hit) o_correct <= sat_inc(o_correct);
        if (N_SAMPLES != 0 && 32'(tot_nx) == N_SAMPLES) o_done <= 1'b1;
      end
      // labels outside the class range never match any k, so only global counters move
      for (int k = 0; k < N_CLASSES; k++)
        if (pop && head == LABEL_W'(k)) begin
          cls_tot[k] <= sat_inc(cls_tot[k]);
          if (hit) cls_cor[k] <= sat_inc(cls_cor[k]);
        end
    end
  end
endmodule
